// File: rtl/bus_scan_arbiter.sv
// bus_scan_arbiter: round-robin grant of one of 16 buses onto the 1-bit demux, with watchdog release
module bus_scan_arbiter #(
    parameter int N_BUS = 16,
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter logic [4:0] IDLE_SEL = 5'h1F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_BUS-1:0] req,
    input  logic             done,
    input  logic             abort,
    output logic [4:0]       sel_out,
    output logic             bus_active,
    output logic             grant_valid,
    output logic [3:0]       last_bus,
    output logic             timeout_err,
    output logic             abort_seen
);
    typedef enum logic [1:0] {IDLE, SELECT, ACTIVE, RELEASE} state_t;
    state_t state, state_nx;
    logic [3:0] idx, idx_nx, ptr, pick;
    logic [TIMEOUT_W-1:0] timer;
    logic to_hit, ab_hit;
    // next state, round-robin pick starting at ptr, and release cause
    always_comb begin
        pick = '0;
        for (int i = N_BUS - 1; i >= 0; i--)
            if (req[ptr + i[3:0]]) pick = i[3:0];
        state_nx = state;
        idx_nx = idx;
        to_hit = 1'b0;
        ab_hit = 1'b0;
        case (state)
            IDLE: if (enable && |req) begin
                state_nx = SELECT;
                idx_nx = ptr + pick;
            end
            SELECT: state_nx = enable ? ACTIVE : RELEASE;
            ACTIVE: begin
                if (done || abort || !enable || timer == TIMEOUT_W'(TIMEOUT_CYC - 1)) state_nx = RELEASE;
                ab_hit = !done && abort;
                to_hit = !done && !abort && enable && timer == TIMEOUT_W'(TIMEOUT_CYC - 1);
            end
            default: state_nx = IDLE;
        endcase
    end
    // state, registered outputs tracking the next state, and round-robin bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            ptr <= '0;
            last_bus <= '0;
            timer <= '0;
            sel_out <= IDLE_SEL;
            bus_active <= 1'b0;
            grant_valid <= 1'b0;
            timeout_err <= 1'b0;
            abort_seen <= 1'b0;
        end else begin
            state <= state_nx;
            idx <= idx_nx;
            timer <= state == ACTIVE ? timer + 1'b1 : '0;
            sel_out <= state_nx == IDLE ? IDLE_SEL : {1'b0, idx_nx};
            bus_active <= state_nx == ACTIVE;
            grant_valid <= state_nx != IDLE;
            timeout_err <= to_hit;
            abort_seen <= ab_hit;
            if (state == RELEASE) begin
                last_bus <= idx;
                ptr <= idx + 1'b1;
            end
        end
    end
endmodule
